// File: rtl/varint_pkg.sv
// Shared types and defaults for the varint decode path.
package varint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        SEND = 2'b10
    } arb_state_e;

    localparam int VARINT_DATA_W = 64;
    localparam int VARINT_IDX_W  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] winner,
    output logic [N-1:0]  gnt
);

    always_comb begin
        int idx;
        logic [N-1:0] sh;
        any    = 1'b0;
        winner = '0;
        gnt    = '0;
        idx    = 0;
        sh     = '0;
        // Start one past ptr so the last winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            sh  = req >> idx;
            if (sh[0] && !any) begin
                any    = 1'b1;
                winner = PW'(idx);
                gnt    = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/varint_rr_arbiter.sv
// Round-robin arbiter sharing one field assembler between varint channels,
// with a registered output stage sustaining one word per cycle.
module varint_rr_arbiter
    import varint_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = VARINT_DATA_W,
    parameter int IDX_W   = VARINT_IDX_W,
    parameter int SRC_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*IDX_W-1:0]   req_index,
    output logic [NUM_REQ-1:0]         req_accepted,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [IDX_W-1:0]           out_index,
    output logic [SRC_W-1:0]           out_src,
    input  logic                       out_accepted,
    output logic [15:0]                grant_count
);

    if (SRC_W != clog2(NUM_REQ)) begin : g_bad_src_w
        $error("SRC_W must equal clog2(NUM_REQ)");
    end

    arb_state_e          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [15:0]         grant_count_q, grant_count_d;

    logic                any;
    logic [SRC_W-1:0]    winner;
    logic [NUM_REQ-1:0]  gnt;
    logic                grant_ok;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (SRC_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .any    (any),
        .winner (winner),
        .gnt    (gnt)
    );

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_index_d   = out_index_q;
        out_src_d     = out_src_q;
        rr_ptr_d      = rr_ptr_q;
        grant_count_d = grant_count_q;
        grant_ok      = 1'b0;

        case (state_q)
            IDLE: grant_ok = 1'b1;
            SEND: grant_ok = out_accepted;
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (grant_ok) begin
            if (any) begin
                state_d     = SEND;
                out_valid_d = 1'b1;
                out_data_d  = req_data[int'(winner)*DATA_W +: DATA_W];
                out_index_d = req_index[int'(winner)*IDX_W +: IDX_W];
                out_src_d   = winner;
                rr_ptr_d    = winner;
                if (grant_count_q != 16'hFFFF) begin
                    grant_count_d = grant_count_q + 16'd1;
                end
            end else begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        end
    end

    // Reset suppresses the combinational accept so no word is lost mid-reset.
    assign req_accepted = (grant_ok && !reset) ? gnt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            out_src_q     <= '0;
            rr_ptr_q      <= SRC_W'(NUM_REQ - 1);
            grant_count_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_index_q   <= out_index_d;
            out_src_q     <= out_src_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign out_src     = out_src_q;
    assign grant_count = grant_count_q;

endmodule

// File: tb/tb_varint_rr_arbiter.sv
// Directed bench for varint_rr_arbiter with hand-computed expectations.
module tb_varint_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int IDX_W   = 8;
    localparam int SRC_W   = 2;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*IDX_W-1:0]  req_index;
    logic [NUM_REQ-1:0]        req_accepted;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [IDX_W-1:0]          out_index;
    logic [SRC_W-1:0]          out_src;
    logic                      out_accepted;
    logic [15:0]               grant_count;

    int n_chk;
    int n_err;

    varint_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W),
        .SRC_W   (SRC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_index    (req_index),
        .req_accepted (req_accepted),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_src      (out_src),
        .out_accepted (out_accepted),
        .grant_count  (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges so no clock edge sees it.
    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    task automatic set_chan(input int i, input logic [63:0] d,
                            input logic [7:0] x);
        req_data[i*DATA_W +: DATA_W] = d;
        req_index[i*IDX_W +: IDX_W]  = x;
    endtask

    initial begin
        int others;
        int max_wait;
        int bad;
        logic [NUM_REQ-1:0] acc;

        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_index = '0;
        out_accepted = 1'b1;

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
        chk("rst_cnt", 64'(grant_count), 64'd0);
        chk("rst_acc", 64'(req_accepted), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single request to channel 2
        set_chan(2, 64'h1234, 8'h05);
        req_valid = 4'b0100;
        #1;
        chk("single_acc", 64'(req_accepted), 64'h4);
        tick();
        req_valid = '0;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", out_data, 64'h1234);
        chk("single_idx", 64'(out_index), 64'h05);
        chk("single_src", 64'(out_src), 64'd2);
        chk("single_cnt", 64'(grant_count), 64'd1);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_hold", out_data, 64'h1234);

        // Round-robin order from reset: 0,1,2,3,0,1
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_chan(i, 64'hA0 + 64'(i), 8'h10 + 8'(i));
        end
        req_valid = 4'b1111;
        out_accepted = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_acc", 64'(req_accepted), 64'(1) << (i % 4));
            tick();
            chk("rr_src", 64'(out_src), 64'(i % 4));
            chk("rr_data", out_data, 64'hA0 + 64'(i % 4));
            chk("rr_valid", 64'(out_valid), 64'd1);
        end

        // Backpressure while holding channel 1's word
        out_accepted = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_acc", 64'(req_accepted), 64'd0);
            tick();
            chk("bp_src", 64'(out_src), 64'd1);
            chk("bp_data", out_data, 64'hA1);
            chk("bp_idx", 64'(out_index), 64'h11);
            chk("bp_valid", 64'(out_valid), 64'd1);
        end
        out_accepted = 1'b1;
        #1;
        chk("bp_rel_acc", 64'(req_accepted), 64'h4);
        tick();
        chk("bp_rel_src", 64'(out_src), 64'd2);
        chk("bp_rel_cnt", 64'(grant_count), 64'd7);

        // Starvation bound for channel 0
        others = 0;
        max_wait = 0;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            req_valid = {3'($urandom_range(0, 7)), 1'b1};
            out_accepted = ($urandom_range(0, 3) != 0);
            #1;
            acc = req_accepted;
            if (((acc & (acc - 1'b1)) != '0) || ((acc & ~req_valid) != '0))
                bad++;
            if (acc[0]) begin
                others = 0;
            end else if (acc != '0) begin
                others++;
                if (others > max_wait) max_wait = others;
            end
            tick();
        end
        chk("starve_onehot", 64'(bad), 64'd0);
        chk("starve_bound", 64'(max_wait > NUM_REQ - 1), 64'd0);

        // Async reset while a word is held
        req_valid = 4'b1111;
        out_accepted = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_cnt", 64'(grant_count), 64'd0);
        chk("async_acc", 64'(req_accepted), 64'd0);
        chk("async_data", out_data, 64'd0);
        #1;
        reset = 1'b0;
        out_accepted = 1'b1;
        #1;
        chk("post_rst_acc", 64'(req_accepted), 64'h1);
        tick();
        chk("post_rst_src", 64'(out_src), 64'd0);
        chk("post_rst_cnt", 64'(grant_count), 64'd1);

        // Saturation of grant_count
        pulse_reset();
        req_valid = 4'b1111;
        out_accepted = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", 64'(grant_count), 64'hFFFE);
        tick();
        chk("sat_ffff", 64'(grant_count), 64'hFFFF);
        repeat (5) tick();
        chk("sat_hold", 64'(grant_count), 64'hFFFF);
        chk("sat_valid", 64'(out_valid), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/varint_rr_arbiter.md
Name: varint_rr_arbiter

Overview:
- Shares one downstream varint consumer (field assembler) between NUM_REQ varint output channels.
- Each channel presents data with the valid/accepted handshake used by the varint output FSMs.
- Round-robin arbitration; registered output stage; back-to-back grants sustain one word per cycle.

Parameters:
- NUM_REQ, 4, number of requesting varint channels (2..8)
- DATA_W, 64, decoded varint width
- IDX_W, 8, field index width
- SRC_W, 2, source id width; must equal clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- reset  in  1  reset. Asynchronous, active-high.
- req_valid  in  NUM_REQ  per-channel varint_data_valid
- req_data  in  NUM_REQ*DATA_W  flat bus; channel i at [i*DATA_W +: DATA_W]
- req_index  in  NUM_REQ*IDX_W  flat bus; channel i at [i*IDX_W +: IDX_W]
- req_accepted  out  NUM_REQ  per-channel varint_data_accepted; one-hot or zero
- out_valid  out  1  downstream data valid
- out_data  out  DATA_W  granted varint
- out_index  out  IDX_W  granted field index
- out_src  out  SRC_W  granted channel id
- out_accepted  in  1  downstream accepts the current word
- grant_count  out  16  saturating count of grants since reset

Behaviour:
- Reset values (async assert): state=IDLE, out_valid=0, out_data=0, out_index=0, out_src=0, rr_ptr=NUM_REQ-1, grant_count=0. req_accepted is combinational and is 0 whenever state=IDLE and req_valid=0.
- Two states, one-hot: IDLE=2'b01, SEND=2'b10. Illegal state goes to IDLE.
- Winner selection (combinational): the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
- grant_ok = (state==IDLE) or (state==SEND and out_accepted).
- If grant_ok and any req_valid:
  - req_accepted[winner]=1 in the same cycle.
  - At the clock edge: latch req_data/req_index[winner] into out_data/out_index, set out_src=winner, rr_ptr=winner, out_valid=1, state=SEND, and increment grant_count (saturates at 16'hFFFF).
- If grant_ok and no req_valid: at the edge out_valid=0 and state=IDLE. out_data, out_index and out_src hold their values.
- In SEND without out_accepted:
  - out_* is held stable and out_valid stays 1.
  - req_accepted=0; no new grant is issued.
- Latency: req_valid high in cycle N while IDLE gives out_valid in cycle N+1.
- Throughput: with continuous requests and out_accepted held high, one grant per cycle.
- Fairness: a channel held valid is granted within NUM_REQ grants.
- The granted channel is skipped on the next arbitration even if it re-asserts valid immediately.
- Simultaneous out_accepted and new requests in SEND: the accept and the new grant happen in the same cycle with no bubble.
- req_valid dropping without acceptance is legal; the arbiter never latches a channel whose valid is low in the grant cycle.
- Reset mid-transfer: the held word is discarded, out_valid drops immediately (async), and no req_accepted is issued.
- Upstream contract: req_data/req_index are stable while req_valid=1 and unaccepted.

Decomposition:
- Shared package varint_pkg holds:
  - the state encodings IDLE/SEND
  - the DATA_W/IDX_W defaults shared with the varint decoder FIFOs
  - a clog2 function for SRC_W checking
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, winner id, one-hot grant.
  - Reusable by other schedulers in the parser.

Test Plan:
- Single request: after reset, req_valid=4'b0100 with data 64'h1234, index 8'h05 held 1 cycle, out_accepted=1. Required: req_accepted=4'b0100 in the same cycle; next cycle out_valid=1, out_data=64'h1234, out_index=8'h05, out_src=2; grant_count=1.
- Round-robin order: req_valid=4'b1111 held, out_accepted=1. Required: grants 0,1,2,3,0,1 on consecutive cycles; each req_accepted one-hot; no idle cycles.
- Downstream backpressure: a grant to channel 1, then out_accepted=0 for 5 cycles while 4'b1111 is requested. Required: out_* stable, req_accepted=0 for those cycles; on the out_accepted=1 cycle channel 2 is accepted.
- Starvation bound: channel 0 held valid, channels 1-3 toggled randomly for 200 cycles. Required: channel 0 is never waiting for more than 4 grants.
- Reset in SEND: async reset pulse mid-cycle while out_valid=1. Required: out_valid=0 and grant_count=0 without a clock edge; after release, the first grant with 4'b1111 goes to channel 0.
- Saturation: force 65540 grants. Required: grant_count stops at 16'hFFFF with no wrap.
